// File: rtl/gpio_bank.sv
`default_nettype none
// ============================================================================
// Module      : gpio_bank
// Description : Parametrised GPIO bank with per-pin direction, atomic set/clear,
//               synchronised inputs and edge-triggered W1C interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_bank #(
  parameter int GPIO_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel,
  input  logic [2:0]            reg_addr,
  input  logic [DATA_WIDTH-1:0] wrdata,
  input  logic                  wren,
  output logic [DATA_WIDTH-1:0] rddata,
  input  logic [GPIO_WIDTH-1:0] gpio_port_in,
  output logic [GPIO_WIDTH-1:0] gpio_port_out,
  output logic [GPIO_WIDTH-1:0] gpio_dir,
  output logic                  irq
);

  localparam logic [2:0] c_ADDR_DATA_OUT   = 3'd0;
  localparam logic [2:0] c_ADDR_DIR        = 3'd1;
  localparam logic [2:0] c_ADDR_DATA_IN    = 3'd2;
  localparam logic [2:0] c_ADDR_IRQ_EN     = 3'd3;
  localparam logic [2:0] c_ADDR_EDGE_SEL   = 3'd4;
  localparam logic [2:0] c_ADDR_IRQ_STATUS = 3'd5;
  localparam logic [2:0] c_ADDR_SET        = 3'd6;
  localparam logic [2:0] c_ADDR_CLR        = 3'd7;

  localparam int                c_WARM_CYCLES = SYNC_STAGES + 1;
  localparam int                c_WARM_W      = $clog2(c_WARM_CYCLES + 1);
  localparam logic [c_WARM_W-1:0] c_WARM_DONE = c_WARM_W'(c_WARM_CYCLES);

  logic [GPIO_WIDTH-1:0]                  r_data_out;
  logic [GPIO_WIDTH-1:0]                  r_dir;
  logic [GPIO_WIDTH-1:0]                  r_irq_en;
  logic [GPIO_WIDTH-1:0]                  r_edge_sel;
  logic [GPIO_WIDTH-1:0]                  r_irq_status;
  logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] r_sync;
  logic [GPIO_WIDTH-1:0]                  r_prev;
  logic [c_WARM_W-1:0]                    r_warm;

  logic                  w_wr;
  logic                  w_armed;
  logic [GPIO_WIDTH-1:0] w_wr_data;
  logic [GPIO_WIDTH-1:0] w_sync;
  logic [GPIO_WIDTH-1:0] w_event;
  logic [GPIO_WIDTH-1:0] w_w1c_mask;
  logic [GPIO_WIDTH-1:0] w_rd_bits;

  assign w_wr      = sel & wren;
  assign w_wr_data = wrdata[GPIO_WIDTH-1:0];
  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_armed   = (r_warm == c_WARM_DONE);

  // Edges are ignored until the zeroed pipeline has been flushed by real pin samples.
  assign w_event = w_armed
                 ? ((r_edge_sel & w_sync & ~r_prev) | (~r_edge_sel & ~w_sync & r_prev))
                 : '0;

  assign w_w1c_mask = (w_wr && reg_addr == c_ADDR_IRQ_STATUS) ? w_wr_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= '0;
      r_warm <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_port_in};
      r_prev <= w_sync;
      if (!w_armed) begin
        r_warm <= r_warm + c_WARM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out   <= '0;
      r_dir        <= '0;
      r_irq_en     <= '0;
      r_edge_sel   <= '0;
      r_irq_status <= '0;
    end else begin
      // OR-ing the event after the clear makes a coincident edge win over W1C.
      r_irq_status <= (r_irq_status & ~w_w1c_mask) | w_event;
      if (w_wr) begin
        case (reg_addr)
          c_ADDR_DATA_OUT: r_data_out <= w_wr_data;
          c_ADDR_DIR:      r_dir      <= w_wr_data;
          c_ADDR_IRQ_EN:   r_irq_en   <= w_wr_data;
          c_ADDR_EDGE_SEL: r_edge_sel <= w_wr_data;
          c_ADDR_SET:      r_data_out <= r_data_out | w_wr_data;
          c_ADDR_CLR:      r_data_out <= r_data_out & ~w_wr_data;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd_bits = '0;
    case (reg_addr)
      c_ADDR_DATA_OUT:   w_rd_bits = r_data_out;
      c_ADDR_DIR:        w_rd_bits = r_dir;
      c_ADDR_DATA_IN:    w_rd_bits = w_sync;
      c_ADDR_IRQ_EN:     w_rd_bits = r_irq_en;
      c_ADDR_EDGE_SEL:   w_rd_bits = r_edge_sel;
      c_ADDR_IRQ_STATUS: w_rd_bits = r_irq_status;
      default:           w_rd_bits = '0;
    endcase
  end

  always_comb begin
    rddata                   = '0;
    rddata[GPIO_WIDTH-1:0]   = w_rd_bits;
  end

  assign gpio_port_out = r_data_out & r_dir;
  assign gpio_dir      = r_dir;
  assign irq           = |(r_irq_status & r_irq_en);

  generate
    if (GPIO_WIDTH < DATA_WIDTH) begin : g_unused_wrdata
      logic w_unused_hi;
      assign w_unused_hi = ^wrdata[DATA_WIDTH-1:GPIO_WIDTH];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_gpio_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_bank
// Description : Directed plus randomised bench for gpio_bank against a
//               pin-history reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_bank;

  localparam int c_W = 8;
  localparam int c_S = 2;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [2:0]  reg_addr;
  logic [31:0] wrdata;
  logic        wren;
  logic [31:0] rddata;
  logic [7:0]  gpio_port_in;
  logic [7:0]  gpio_port_out;
  logic [7:0]  gpio_dir;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register contents plus every pin sample taken since reset.
  logic [7:0] m_data_out, m_dir, m_en, m_edge, m_status;
  logic [7:0] samp[$];

  gpio_bank #(.GPIO_WIDTH(c_W), .SYNC_STAGES(c_S), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .sel          (sel),
    .reg_addr     (reg_addr),
    .wrdata       (wrdata),
    .wren         (wren),
    .rddata       (rddata),
    .gpio_port_in (gpio_port_in),
    .gpio_port_out(gpio_port_out),
    .gpio_dir     (gpio_dir),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_data_in();
    int n = samp.size();
    return (n >= c_S) ? samp[n-c_S] : 8'h00;
  endfunction

  task automatic model_clear();
    m_data_out = 8'h00; m_dir = 8'h00; m_en = 8'h00; m_edge = 8'h00; m_status = 8'h00;
    samp.delete();
  endtask

  // One clock: drive inputs, advance the model across the edge, then settle.
  task automatic step(input logic s, input logic w, input logic [2:0] a,
                      input logic [31:0] d, input logic [7:0] pins);
    logic [7:0] ev, old_v, new_v;
    int m;
    sel = s; wren = w; reg_addr = a; wrdata = d; gpio_port_in = pins;
    ev = 8'h00;
    m  = samp.size();
    if (m >= c_S + 1) begin
      old_v = samp[m-c_S-1];
      new_v = samp[m-c_S];
      for (int i = 0; i < c_W; i++) begin
        if (m_edge[i] ? (!old_v[i] && new_v[i]) : (old_v[i] && !new_v[i])) ev[i] = 1'b1;
      end
    end
    samp.push_back(pins);
    if (s && w && a == 3'd5) m_status = m_status & ~d[7:0];
    m_status = m_status | ev;
    if (s && w) begin
      case (a)
        3'd0: m_data_out = d[7:0];
        3'd1: m_dir      = d[7:0];
        3'd3: m_en       = d[7:0];
        3'd4: m_edge     = d[7:0];
        3'd6: m_data_out = m_data_out | d[7:0];
        3'd7: m_data_out = m_data_out & ~d[7:0];
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    sel = 1'b0; wren = 1'b0;
  endtask

  task automatic idle(input int n, input logic [7:0] pins);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 3'd0, 32'h0, pins);
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    reg_addr = a;
    #1;
    check(tag, rddata, exp);
  endtask

  task automatic check_all(input string ctx);
    logic [7:0] exp_r[8];
    exp_r = '{m_data_out, m_dir, m_data_in(), m_en, m_edge, m_status, 8'h00, 8'h00};
    for (int a = 0; a < 8; a++) begin
      read_check($sformatf("%s rd%0d", ctx, a), 3'(a), {24'h0, exp_r[a]});
    end
    check({ctx, " port_out"}, {24'h0, gpio_port_out}, {24'h0, m_data_out & m_dir});
    check({ctx, " dir"}, {24'h0, gpio_dir}, {24'h0, m_dir});
    check({ctx, " irq"}, {31'h0, irq}, {31'h0, |(m_status & m_en)});
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; wren = 1'b0; reg_addr = 3'd0; wrdata = 32'h0;
    gpio_port_in = 8'hFF;
    model_clear();

    // Reset state and warm-up with all pins high
    #5;
    check_all("in_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    check_all("post_reset");
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 3'd0, 32'h0, 8'hFF);
      check_all($sformatf("warmup%0d", k));
      check("warmup irq", {31'h0, irq}, 32'h0);
    end

    // Direction, data, set and clear
    step(1'b1, 1'b1, 3'd1, 32'h0000_000F, 8'hFF);
    step(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 8'hFF);
    check_all("dir_data");
    check("port_out_0F", {24'h0, gpio_port_out}, 32'h0F);
    step(1'b1, 1'b1, 3'd6, 32'h0000_0030, 8'hFF);
    step(1'b1, 1'b1, 3'd7, 32'h0000_0001, 8'hFF);
    check_all("set_clr");
    read_check("data_out_FE", 3'd0, 32'hFE);
    check("port_out_0E", {24'h0, gpio_port_out}, 32'h0E);

    // Rising edge on pin 3
    step(1'b1, 1'b1, 3'd4, 32'h0000_0008, 8'h00);
    idle(4, 8'h00);
    step(1'b1, 1'b1, 3'd5, 32'h0000_00FF, 8'h00);
    step(1'b1, 1'b1, 3'd3, 32'h0000_0008, 8'h00);
    check_all("pre_rise");
    read_check("status_clear", 3'd5, 32'h0);
    step(1'b0, 1'b0, 3'd0, 32'h0, 8'h08);
    read_check("din_edge0", 3'd2, 32'h0);
    step(1'b0, 1'b0, 3'd0, 32'h0, 8'h08);
    read_check("din_edge1", 3'd2, 32'h08);
    read_check("status_edge1", 3'd5, 32'h0);
    step(1'b0, 1'b0, 3'd0, 32'h0, 8'h08);
    read_check("status_edge2", 3'd5, 32'h08);
    check("irq_edge2", {31'h0, irq}, 32'h1);
    check_all("rise3");
    step(1'b1, 1'b1, 3'd5, 32'h0000_0008, 8'h08);
    read_check("status_w1c", 3'd5, 32'h0);
    check("irq_w1c", {31'h0, irq}, 32'h0);

    // Falling edge on pin 5 with its interrupt masked
    step(1'b1, 1'b1, 3'd3, 32'h0000_0000, 8'h28);
    idle(3, 8'h28);
    check_all("pre_fall");
    idle(3, 8'h08);
    read_check("status_fall5", 3'd5, 32'h20);
    check("irq_masked", {31'h0, irq}, 32'h0);
    step(1'b1, 1'b1, 3'd3, 32'h0000_0020, 8'h08);
    check("irq_unmasked", {31'h0, irq}, 32'h1);
    check_all("fall5");

    // W1C coinciding with a new rising event on pin 3
    idle(3, 8'h20);
    step(1'b0, 1'b0, 3'd0, 32'h0, 8'h28);
    step(1'b0, 1'b0, 3'd0, 32'h0, 8'h28);
    step(1'b1, 1'b1, 3'd5, 32'h0000_0008, 8'h28);
    read_check("set_wins", 3'd5, 32'h28);
    check_all("set_wins");

    // Asynchronous reset mid-stream
    step(1'b1, 1'b1, 3'd0, 32'h0000_00AA, 8'h28);
    step(1'b1, 1'b1, 3'd1, 32'h0000_00FF, 8'h28);
    check("pre_rst_port", {24'h0, gpio_port_out}, 32'hAA);
    #5;
    rst = 1'b1;
    #1;
    model_clear();
    check("async_port_out", {24'h0, gpio_port_out}, 32'h0);
    check("async_dir", {24'h0, gpio_dir}, 32'h0);
    check("async_irq", {31'h0, irq}, 32'h0);
    read_check("async_status", 3'd5, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b0, 1'b1, 3'd0, 32'h0000_0055, 8'h28);
    check_all("unselected_write");

    // Randomised traffic
    begin
      logic [7:0] pins = 8'h28;
      for (int it = 0; it < 300; it++) begin
        if ($urandom_range(0, 2) == 0) pins = 8'($urandom);
        if (it == 150) begin
          rst = 1'b1;
          #1;
          model_clear();
          @(posedge clk); #1;
          rst = 1'b0;
        end
        step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             3'($urandom_range(0, 7)), $urandom, pins);
        check_all($sformatf("rand%0d", it));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
